// File: rtl/stepper_indexer.sv
// Carousel indexer: turns a slot request into the shortest-direction run of
// stepper phase patterns, with a prescaled step rate and done/err pulses.
`timescale 1ns/1ps
module stepper_indexer #(
    parameter int NUM_SLOTS      = 4,
    parameter int STEPS_PER_SLOT = 512,
    parameter int STEP_DIV       = 200000,
    parameter int HOLD           = 1,
    localparam int SLOT_W        = ($clog2(NUM_SLOTS) > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [SLOT_W-1:0] cmd_slot,
    input  logic              cmd_half,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SLOT_W-1:0] cur_slot,
    output logic [3:0]        coils
);

    // Worst case is half the ring in half-step mode: NUM_SLOTS * STEPS_PER_SLOT steps.
    localparam int STEP_W = $clog2(NUM_SLOTS * STEPS_PER_SLOT + 1);
    localparam int PRE_W  = $clog2(STEP_DIV);
    localparam logic [PRE_W-1:0]  DIV_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [SLOT_W:0]   N_V      = (SLOT_W + 1)'(NUM_SLOTS);
    localparam logic [SLOT_W:0]   HALF_V   = (SLOT_W + 1)'(NUM_SLOTS / 2);

    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DONE = 2'd2} state_t;

    state_t              state_r, state_s;
    logic [2:0]          p_r, p_s, p_inc_s;
    logic [SLOT_W-1:0]   cur_slot_r, cur_slot_s, target_r, target_s;
    logic                rev_r, rev_s, half_r, half_s;
    logic [PRE_W-1:0]    presc_r, presc_s;
    logic [STEP_W-1:0]   steps_r, steps_s, steps_load_s;
    logic [SLOT_W:0]     diff_s, slots_s;
    logic                fwd_s, accept_s;
    logic                done_r, done_s, err_r, err_s, busy_r, busy_s, ready_r, ready_s;
    logic [3:0]          coils_r, coils_s;

    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            3'd7:    pat = 4'b1001;
            default: pat = 4'b0000;
        endcase
        return pat;
    endfunction

    // Command decode: ring distance, direction choice and step budget.
    always_comb begin
        accept_s = cmd_valid && ready_r;
        if ({1'b0, cmd_slot} >= {1'b0, cur_slot_r}) begin
            diff_s = {1'b0, cmd_slot} - {1'b0, cur_slot_r};
        end else begin
            diff_s = {1'b0, cmd_slot} + N_V - {1'b0, cur_slot_r};
        end
        fwd_s        = (diff_s <= HALF_V);
        slots_s      = fwd_s ? diff_s : (N_V - diff_s);
        steps_load_s = STEP_W'(slots_s) * STEP_W'(STEPS_PER_SLOT);
        if (cmd_half) begin
            steps_load_s = steps_load_s << 1'b1;
        end else begin
            steps_load_s = steps_load_s;
        end
        p_inc_s = half_r ? 3'd1 : 3'd2;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        p_s        = p_r;
        cur_slot_s = cur_slot_r;
        target_s   = target_r;
        rev_s      = rev_r;
        half_s     = half_r;
        presc_s    = presc_r;
        steps_s    = steps_r;
        done_s     = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_s = IDLE;
                end else if ({1'b0, cmd_slot} >= N_V) begin
                    err_s = 1'b1;
                end else if (cmd_slot == cur_slot_r) begin
                    done_s = 1'b1;
                end else begin
                    state_s  = MOVE;
                    target_s = cmd_slot;
                    rev_s    = ~fwd_s;
                    half_s   = cmd_half;
                    presc_s  = '0;
                    steps_s  = steps_load_s;
                end
            end
            MOVE: begin
                if (presc_r == DIV_LAST) begin
                    presc_s = '0;
                    p_s     = rev_r ? (p_r - p_inc_s) : (p_r + p_inc_s);
                    steps_s = steps_r - STEP_W'(1);
                    if (steps_r == STEP_W'(1)) begin
                        state_s    = DONE;
                        done_s     = 1'b1;
                        cur_slot_s = target_r;
                    end else begin
                        state_s = MOVE;
                    end
                end else begin
                    presc_s = presc_r + PRE_W'(1);
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        ready_s = (state_s == IDLE);
        busy_s  = (state_s == MOVE);
        coils_s = (busy_s || (HOLD != 0)) ? phase_pattern(p_s) : 4'b0000;
    end

    // State and output registers; reset abandons any move in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            p_r        <= 3'd0;
            cur_slot_r <= '0;
            target_r   <= '0;
            rev_r      <= 1'b0;
            half_r     <= 1'b0;
            presc_r    <= '0;
            steps_r    <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b0;
            coils_r    <= 4'b0000;
        end else begin
            state_r    <= state_s;
            p_r        <= p_s;
            cur_slot_r <= cur_slot_s;
            target_r   <= target_s;
            rev_r      <= rev_s;
            half_r     <= half_s;
            presc_r    <= presc_s;
            steps_r    <= steps_s;
            done_r     <= done_s;
            err_r      <= err_s;
            busy_r     <= busy_s;
            ready_r    <= ready_s;
            coils_r    <= coils_s;
        end
    end

    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign cur_slot  = cur_slot_r;
    assign coils     = coils_r;

endmodule

// File: tb/tb_stepper_indexer.sv
// Bench for stepper_indexer: directed scenarios plus random moves against a
// slot/phase reference model; a second instance covers NUM_SLOTS=5 and HOLD=0.
`timescale 1ns/1ps
module tb_stepper_indexer;

    localparam int NS  = 4;
    localparam int SPS = 2;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_half;
    logic [1:0] cmd_slot;
    logic       cmd_ready, busy, done, err;
    logic [1:0] cur_slot;
    logic [3:0] coils;

    logic       b_rst, b_cmd_valid, b_cmd_half;
    logic [2:0] b_cmd_slot;
    logic       b_cmd_ready, b_busy, b_done, b_err;
    logic [2:0] b_cur_slot;
    logic [3:0] b_coils;

    int vectors = 0;
    int miscompares = 0;
    int cur_m = 0;
    int p_m = 0;
    logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    always #5 clk = ~clk;

    stepper_indexer #(.NUM_SLOTS(NS), .STEPS_PER_SLOT(SPS), .STEP_DIV(DIV), .HOLD(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_slot(cmd_slot), .cmd_half(cmd_half),
        .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err), .cur_slot(cur_slot), .coils(coils));

    stepper_indexer #(.NUM_SLOTS(5), .STEPS_PER_SLOT(SPS), .STEP_DIV(DIV), .HOLD(0)) dut_b (
        .clk(clk), .rst(b_rst), .cmd_valid(b_cmd_valid), .cmd_slot(b_cmd_slot), .cmd_half(b_cmd_half),
        .cmd_ready(b_cmd_ready), .busy(b_busy), .done(b_done), .err(b_err), .cur_slot(b_cur_slot),
        .coils(b_coils));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wrap8(input int x);
        return ((x % 8) + 8) % 8;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_coils", 32'(coils), 32'h0);
        check("rst_cur", 32'(cur_slot), 32'h0);
        check("rst_busy_done_err", {29'd0, busy, done, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'h1);
        check("post_rst_coils", 32'(coils), 32'(pat[0]));
        cur_m = 0;
        p_m   = 0;
    endtask

    // Issues one command and follows it edge by edge against the model.
    task automatic do_move(input int slot, input bit half, input bit junk);
        int d, slots, dir, inc, steps, total;
        cmd_valid = 1'b1;
        cmd_slot  = 2'(slot);
        cmd_half  = half;
        @(negedge clk);
        if (junk) begin
            cmd_slot = 2'(slot + 1);
            cmd_half = ~half;
        end else begin
            cmd_valid = 1'b0;
        end
        d = (slot - cur_m + NS) % NS;
        if (d == 0) begin
            cmd_valid = 1'b0;
            check("same_done", 32'(done), 32'h1);
            check("same_busy", 32'(busy), 32'h0);
            check("same_coils", 32'(coils), 32'(pat[p_m]));
            @(negedge clk);
            check("same_done_clear", 32'(done), 32'h0);
            check("same_cur", 32'(cur_slot), 32'(cur_m));
            return;
        end
        if (d <= NS / 2) begin
            slots = d;
            dir   = 1;
        end else begin
            slots = NS - d;
            dir   = -1;
        end
        inc   = half ? 1 : 2;
        steps = slots * SPS * (half ? 2 : 1);
        total = steps * DIV;
        check("mv_start_busy", {30'd0, busy, cmd_ready}, 32'h2);
        check("mv_start_coils", 32'(coils), 32'(pat[p_m]));
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            check("mv_coils", 32'(coils), 32'(pat[wrap8(p_m + dir * inc * (k / DIV))]));
            if (k < total) begin
                check("mv_running", {30'd0, busy, done}, 32'h2);
            end else begin
                check("mv_done", {29'd0, busy, done, cmd_ready}, 32'h2);
                check("mv_cur", 32'(cur_slot), 32'(slot));
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mv_idle", {29'd0, busy, done, cmd_ready}, 32'h1);
        p_m   = wrap8(p_m + dir * inc * steps);
        cur_m = slot;
        check("mv_hold_coils", 32'(coils), 32'(pat[p_m]));
        check("mv_cur_hold", 32'(cur_slot), 32'(cur_m));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_slot = 2'd0; cmd_half = 1'b0;
        b_rst = 1'b1; b_cmd_valid = 1'b0; b_cmd_slot = 3'd0; b_cmd_half = 1'b0;
        #1;
        check("init_rst_coils", 32'(coils), 32'h0);
        check("init_rst_ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // full-step 0->1, reverse 0->3, half-step tie 0->2
        do_reset();
        do_move(1, 1'b0, 1'b0);
        check("full_p4", 32'(coils), 32'(4'b0010));
        do_reset();
        do_move(3, 1'b0, 1'b0);
        check("rev_p4", 32'(coils), 32'(4'b0010));
        do_reset();
        do_move(2, 1'b1, 1'b0);
        check("half_p0", 32'(coils), 32'(4'b1000));

        // same-slot request, then a move with cmd_valid held and slot changed throughout
        do_move(2, 1'b0, 1'b0);
        do_move(0, 1'b0, 1'b1);

        // reset in the middle of a move
        cmd_valid = 1'b1;
        cmd_slot  = 2'(cur_m + 1);
        cmd_half  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("abort_coils", 32'(coils), 32'h0);
        check("abort_cur", 32'(cur_slot), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(cmd_ready), 32'h1);
        cur_m = 0;
        p_m   = 0;

        for (int i = 0; i < 12; i++) begin
            do_move(int'($urandom_range(0, NS - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // NUM_SLOTS=5, HOLD=0 instance: out-of-range rejects, coils dark when idle
        @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);
        check("b_idle_coils", 32'(b_coils), 32'h0);
        check("b_ready", 32'(b_cmd_ready), 32'h1);
        for (int s = 5; s <= 6; s++) begin
            b_cmd_valid = 1'b1;
            b_cmd_slot  = 3'(s);
            @(negedge clk);
            b_cmd_valid = 1'b0;
            check("b_err", {29'd0, b_err, b_busy, b_done}, 32'h4);
            check("b_err_coils", 32'(b_coils), 32'h0);
            check("b_err_cur", 32'(b_cur_slot), 32'h0);
            @(negedge clk);
            check("b_err_clear", {30'd0, b_err, b_cmd_ready}, 32'h1);
        end
        b_cmd_valid = 1'b1;
        b_cmd_slot  = 3'd1;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        check("b_mv_coils0", 32'(b_coils), 32'(pat[0]));
        for (int k = 1; k <= 2 * DIV; k++) begin
            @(negedge clk);
            if (k < 2 * DIV) begin
                check("b_mv_coils", 32'(b_coils), 32'(pat[2 * (k / DIV)]));
            end else begin
                check("b_done_coils", 32'(b_coils), 32'h0);
                check("b_done", {30'd0, b_done, b_busy}, 32'h2);
                check("b_cur", 32'(b_cur_slot), 32'h1);
            end
        end
        @(negedge clk);
        check("b_after_coils", 32'(b_coils), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
